intersection_ctrl: RTL
======================

INTERSECTION_CTRL -- requirements
Module: intersection_ctrl

Interface
REQ-001 Parameter GREEN_MIN, default 8: minimum green duration in cycles, both roads.
REQ-002 Parameter GREEN_MAX, default 20: maximum side-road green duration in cycles.
REQ-003 Parameter YELLOW_T, default 3: yellow duration in cycles.
REQ-004 Parameter ALLRED_T, default 2: all-red clearance duration in cycles.
REQ-005 Parameter WALK_T, default 6: pedestrian walk duration in cycles.
REQ-006 clk  input  1  single clock, all state on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 side_car  input  1  side-road vehicle sensor, level.
REQ-009 ped_req  input  1  pedestrian button, any pulse width.
REQ-010 main_light  output  2  main-road lamp: 00 RED, 01 GREEN, 10 YELLOW.
REQ-011 side_light  output  2  side-road lamp, same encoding.
REQ-012 walk  output  1  pedestrian walk lamp.
REQ-013 phase  output  3  current state encoding, for debug.

Function
REQ-014 States SHALL be MAIN_GREEN, MAIN_YELLOW, ALL_RED_1, SIDE_GREEN, SIDE_YELLOW, ALL_RED_2, PED_WALK.
REQ-015 Outputs SHALL be Moore, decoded from the state register only: green/yellow on the active road, RED elsewhere; walk=1 only in PED_WALK; both roads RED in ALL_RED_x and PED_WALK.
REQ-016 Timer SHALL count cycles spent in the current state, starting at 0, and clear to 0 on every transition.
REQ-017 MAIN_GREEN -> MAIN_YELLOW when timer >= GREEN_MIN-1 and (side_car or ped_pending); otherwise hold indefinitely.
REQ-018 MAIN_YELLOW -> ALL_RED_1 at timer == YELLOW_T-1.
REQ-019 ALL_RED_1 -> PED_WALK at timer == ALLRED_T-1 if ped_pending, else -> SIDE_GREEN.
REQ-020 SIDE_GREEN -> SIDE_YELLOW when (timer >= GREEN_MIN-1 and !side_car) or timer == GREEN_MAX-1.
REQ-021 SIDE_YELLOW -> ALL_RED_2 at timer == YELLOW_T-1.
REQ-022 PED_WALK -> ALL_RED_2 at timer == WALK_T-1.
REQ-023 ALL_RED_2 -> MAIN_GREEN at timer == ALLRED_T-1.
REQ-024 ped_pending SHALL set on ped_req in any state except PED_WALK, and clear on the transition into PED_WALK; ped_req coincident with that transition SHALL be absorbed.
REQ-025 Timer width SHALL be sized from the largest parameter; no wrap is reachable.
REQ-026 Parameters SHALL be >= 1 and GREEN_MIN <= GREEN_MAX; violation is an elaboration error.

Reset
REQ-027 reset SHALL override all inputs: state MAIN_GREEN, timer 0, ped_pending 0.
REQ-028 During and after reset, outputs SHALL be main_light=01, side_light=00, walk=0, phase=MAIN_GREEN encoding; reset mid-phase SHALL return to this state on the next edge.

Configuration
REQ-029 Macro INTERSECTION_PED_EN defined: pedestrian logic per REQ-019/022/024.
REQ-030 Macro undefined: ped_req ignored, ped_pending absent, PED_WALK unreachable, walk tied 0, ALL_RED_1 always -> SIDE_GREEN.

Structure
REQ-031 Package traffic_pkg SHALL hold the lamp encoding constants and the state enum typedef.
REQ-032 Sub-module phase_timer (clear, count, terminal-compare) SHALL implement the timer.

Verification (defaults, cycle 0 = first edge after reset release)
REQ-033 No demand for 100 cycles -> main_light=01, side_light=00 throughout.
REQ-034 side_car held 1 -> main YELLOW cycles 8-10, all RED 11-12, side GREEN 13-32 (capped by GREEN_MAX), side YELLOW 33-35, all RED 36-37, main GREEN at 38.
REQ-035 side_car 1 for cycles 0-14 only -> side GREEN 13-20, side YELLOW from cycle 21.
REQ-036 PED_EN, single-cycle ped_req at cycle 2 -> main YELLOW 8-10, all RED 11-12, walk=1 cycles 13-18, all RED 19-20, main GREEN at 21.
REQ-037 reset asserted during SIDE_GREEN -> next edge main_light=01, side_light=00, timer 0, pending cleared.
REQ-038 PED_EN undefined, ped_req pulsed -> no transition out of MAIN_GREEN, walk stays 0.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared lamp encodings, controller phase enum and a small constant helper
// for the intersection controller.
package traffic_pkg;

  localparam logic [1:0] LampRed    = 2'b00;
  localparam logic [1:0] LampGreen  = 2'b01;
  localparam logic [1:0] LampYellow = 2'b10;

  typedef enum logic [2:0] {
    StMainGreen  = 3'd0,
    StMainYellow = 3'd1,
    StAllRed1    = 3'd2,
    StSideGreen  = 3'd3,
    StSideYellow = 3'd4,
    StAllRed2    = 3'd5,
    StPedWalk    = 3'd6
  } phase_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-phase cycle counter: clears on request, otherwise counts up and
// saturates so an indefinitely held phase never wraps.
module phase_timer #(
  parameter int unsigned Width = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [Width-1:0] limit,
  output logic [Width-1:0] count,
  output logic             reached
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_q != {Width{1'b1}}) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign reached = (count_q >= limit);

endmodule

// File: rtl/intersection_ctrl.sv
// Two-road traffic light controller with side-road sensor and optional
// pedestrian phase (enabled by defining INTERSECTION_PED_EN).
module intersection_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned GREEN_MIN = 8,
  parameter int unsigned GREEN_MAX = 20,
  parameter int unsigned YELLOW_T  = 3,
  parameter int unsigned ALLRED_T  = 2,
  parameter int unsigned WALK_T    = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       side_car,
  input  logic       ped_req,
  output logic [1:0] main_light,
  output logic [1:0] side_light,
  output logic       walk,
  output logic [2:0] phase
);

  localparam int unsigned TimerMax =
    max_u(max_u(max_u(GREEN_MIN, GREEN_MAX), max_u(YELLOW_T, ALLRED_T)), WALK_T);
  localparam int unsigned TW = $clog2(TimerMax + 1);

  if (GREEN_MIN < 1 || GREEN_MAX < 1 || YELLOW_T < 1 || ALLRED_T < 1 || WALK_T < 1 ||
      GREEN_MIN > GREEN_MAX) begin : g_bad_params
    $error("intersection_ctrl: timing parameters must be >= 1 and GREEN_MIN <= GREEN_MAX");
  end

  phase_e          state_q, state_d;
  logic [TW-1:0]   limit;
  logic [TW-1:0]   count;
  logic            reached;
  logic            leave;
  logic            ped_pending;

  assign leave = (state_d != state_q);

  phase_timer #(
    .Width (TW)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (leave),
    .limit   (limit),
    .count   (count),
    .reached (reached)
  );

  always_comb begin
    state_d = state_q;
    limit   = TW'(GREEN_MIN - 1);
    case (state_q)
      StMainGreen: begin
        limit = TW'(GREEN_MIN - 1);
        if (reached && (side_car || ped_pending)) state_d = StMainYellow;
      end
      StMainYellow: begin
        limit = TW'(YELLOW_T - 1);
        if (reached) state_d = StAllRed1;
      end
      StAllRed1: begin
        limit = TW'(ALLRED_T - 1);
        if (reached) state_d = ped_pending ? StPedWalk : StSideGreen;
      end
      StSideGreen: begin
        // Gap-out after the minimum, forced out at the maximum.
        limit = TW'(GREEN_MIN - 1);
        if ((reached && !side_car) || (count == TW'(GREEN_MAX - 1))) state_d = StSideYellow;
      end
      StSideYellow: begin
        limit = TW'(YELLOW_T - 1);
        if (reached) state_d = StAllRed2;
      end
      StAllRed2: begin
        limit = TW'(ALLRED_T - 1);
        if (reached) state_d = StMainGreen;
      end
      StPedWalk: begin
        limit = TW'(WALK_T - 1);
        if (reached) state_d = StAllRed2;
      end
      default: state_d = StMainGreen;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StMainGreen;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef INTERSECTION_PED_EN
  logic ped_pending_q, ped_pending_d;

  // Entering the walk phase wins over a coincident button press.
  always_comb begin
    ped_pending_d = ped_pending_q;
    if (state_d == StPedWalk && state_q != StPedWalk) begin
      ped_pending_d = 1'b0;
    end else if (ped_req && state_q != StPedWalk) begin
      ped_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ped_pending_q <= 1'b0;
    end else begin
      ped_pending_q <= ped_pending_d;
    end
  end

  assign ped_pending = ped_pending_q;
  assign walk        = (state_q == StPedWalk);
`else
  logic unused_ped_req;

  assign unused_ped_req = ped_req;
  assign ped_pending    = 1'b0;
  assign walk           = 1'b0;
`endif

  always_comb begin
    main_light = LampRed;
    side_light = LampRed;
    case (state_q)
      StMainGreen:  main_light = LampGreen;
      StMainYellow: main_light = LampYellow;
      StSideGreen:  side_light = LampGreen;
      StSideYellow: side_light = LampYellow;
      default: ;
    endcase
  end

  assign phase = state_q;

endmodule
